// File: rtl/img_diff_if.sv
// Pixel-stream bus for img_diff_stream. The producer drives pixels and mode, and the
// consumer drives the difference stream and the busy flag.
interface img_diff_if #(
  parameter int PIX_W = 4
) ();
  logic             in_valid;
  logic [PIX_W-1:0] in_image;
  logic [1:0]       mode;
  logic             out_valid;
  logic [PIX_W-1:0] out_diff;
  logic             busy;

  modport master (
    output in_valid, in_image, mode,
    input  out_valid, out_diff, busy
  );

  modport slave (
    input  in_valid, in_image, mode,
    output out_valid, out_diff, busy
  );
endinterface

// File: rtl/img_diff_stream.sv
// Streams image A into a buffer, then emits one registered per-pixel difference for
// each image B pixel. The arithmetic mode is latched on the first A beat of a frame.
module img_diff_stream #(
  parameter int PIX_W = 4,
  parameter int N_PIX = 9
) (
  input  logic      clk,
  input  logic      rst_n,
  img_diff_if.slave bus
);
  localparam int            CW   = $clog2(2*N_PIX);
  localparam int            AW   = $clog2(N_PIX);
  localparam logic [CW-1:0] LAST = CW'(N_PIX-1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_A = 2'd1, LOAD_B = 2'd2} state_t;

  // Clamp a signed (PIX_W+1)-bit difference at zero.
  function automatic logic [PIX_W-1:0] sat_zero(input logic signed [PIX_W:0] d);
    return d[PIX_W] ? '0 : d[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] diff_calc(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b,
                                                 input logic [1:0]       m);
    logic signed [PIX_W:0] d_ab;
    logic signed [PIX_W:0] d_ba;
    logic [PIX_W-1:0]      res;
    d_ab = $signed({1'b0, a}) - $signed({1'b0, b});
    d_ba = $signed({1'b0, b}) - $signed({1'b0, a});
    case (m)
      2'd0:    res = d_ab[PIX_W-1:0];
      2'd1:    res = sat_zero(d_ab);
      // At most one direction is positive, so OR-ing the clamped pair gives |a-b|.
      2'd2:    res = sat_zero(d_ab) | sat_zero(d_ba);
      default: res = d_ba[PIX_W-1:0];
    endcase
    return res;
  endfunction

  state_t                 state_q, state_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [1:0]             mode_q, mode_nxt;
  logic [PIX_W-1:0]       a_mem [N_PIX];
  logic [AW-1:0]          a_idx;
  logic                   unused_cnt_msb;
  logic                   wr_en;
  logic                   vld_p0, vld_p1;
  logic [PIX_W-1:0]       diff_p0, diff_p1;
  logic                   busy_q, busy_nxt;

  // cnt never exceeds N_PIX-1, and it is 0 in IDLE, so the low bits address A directly.
  assign a_idx          = cnt_q[AW-1:0];
  assign unused_cnt_msb = cnt_q[CW-1];

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    mode_nxt  = mode_q;
    wr_en     = 1'b0;
    vld_p0    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          wr_en     = 1'b1;
          mode_nxt  = bus.mode;
          cnt_nxt   = CW'(1);
          state_nxt = LOAD_A;
        end
      end
      LOAD_A: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_B;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (bus.in_valid) begin
          vld_p0 = 1'b1;
          if (cnt_q == LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A B beat this cycle always yields an output pulse next cycle, so busy covers it.
    busy_nxt = (state_nxt != IDLE) || vld_p0;
  end

  assign diff_p0 = diff_calc(a_mem[a_idx], bus.in_image, mode_q);

  // p0 -> p1: register control, result and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 2'd0;
      vld_p1  <= 1'b0;
      diff_p1 <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      mode_q  <= mode_nxt;
      vld_p1  <= vld_p0;
      busy_q  <= busy_nxt;
      if (vld_p0) diff_p1 <= diff_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) a_mem[a_idx] <= bus.in_image;
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_diff  = diff_p1;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_img_diff_stream.sv
// Directed bench for img_diff_stream: 4-bit/9-pixel and 8-bit/16-pixel instances,
// with hand-computed expected differences per mode.
module tb_img_diff_stream;
  typedef logic [3:0] vec9_t  [9];
  typedef logic [7:0] vec16_t [16];

  localparam vec9_t A_INC   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  localparam vec9_t B_3     = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
  localparam vec9_t A_15    = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
  localparam vec9_t B_INC0  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  localparam vec9_t E_WRAP  = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam vec9_t E_SAT   = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam vec9_t E_ABS   = '{4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam vec9_t E_RWRAP = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10};
  localparam vec9_t E_F2ABS = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7};
  localparam vec16_t E8_SAT  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                 8'd0, 8'd0, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
  localparam vec16_t E8_WRAP = '{8'd156, 8'd166, 8'd176, 8'd186, 8'd196, 8'd206, 8'd216, 8'd226,
                                 8'd236, 8'd246, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  img_diff_if #(.PIX_W(4)) bus4 ();
  img_diff_if #(.PIX_W(8)) bus8 ();

  img_diff_stream #(.PIX_W(4), .N_PIX(9))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  img_diff_stream #(.PIX_W(8), .N_PIX(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
  task automatic beat4(input logic v, input logic [3:0] p, input logic [1:0] m);
    @(negedge clk);
    bus4.in_valid = v; bus4.in_image = p; bus4.mode = m;
    @(posedge clk); #1;
  endtask

  task automatic beat8(input logic v, input logic [7:0] p, input logic [1:0] m);
    @(negedge clk);
    bus8.in_valid = v; bus8.in_image = p; bus8.mode = m;
    @(posedge clk); #1;
  endtask

  // Sends one frame on bus4; a set bit k in gap_a/gap_b inserts an idle cycle before beat k.
  task automatic run_frame4(input string name, input vec9_t a, input vec9_t b,
                            input logic [1:0] m, input logic [1:0] m_later,
                            input logic [8:0] gap_a, input logic [8:0] gap_b,
                            input vec9_t exp, input bit chk_end);
    for (int k = 0; k < 9; k++) begin
      if (gap_a[k]) begin
        beat4(1'b0, 4'd0, m_later);
        n_checks++;
        if (bus4.out_valid !== 1'b0) $display("FAIL %s A-gap%0d out_valid got %b want 0", name, k, bus4.out_valid);
        else n_pass++;
      end
      beat4(1'b1, a[k], (k == 0) ? m : m_later);
      n_checks++;
      if (bus4.out_valid !== 1'b0) $display("FAIL %s A%0d out_valid got %b want 0", name, k, bus4.out_valid);
      else n_pass++;
      n_checks++;
      if (bus4.busy !== 1'b1) $display("FAIL %s A%0d busy got %b want 1", name, k, bus4.busy);
      else n_pass++;
    end
    for (int k = 0; k < 9; k++) begin
      if (gap_b[k]) begin
        beat4(1'b0, 4'd0, m_later);
        n_checks++;
        if (bus4.out_valid !== 1'b0) $display("FAIL %s B-gap%0d out_valid got %b want 0", name, k, bus4.out_valid);
        else n_pass++;
        n_checks++;
        if (bus4.busy !== 1'b1) $display("FAIL %s B-gap%0d busy got %b want 1", name, k, bus4.busy);
        else n_pass++;
      end
      beat4(1'b1, b[k], m_later);
      n_checks++;
      if (bus4.out_valid !== 1'b1) $display("FAIL %s B%0d out_valid got %b want 1", name, k, bus4.out_valid);
      else n_pass++;
      n_checks++;
      if (bus4.out_diff !== exp[k]) $display("FAIL %s B%0d out_diff got %0d want %0d", name, k, bus4.out_diff, exp[k]);
      else n_pass++;
      n_checks++;
      if (bus4.busy !== 1'b1) $display("FAIL %s B%0d busy got %b want 1", name, k, bus4.busy);
      else n_pass++;
    end
    if (chk_end) begin
      beat4(1'b0, 4'd0, m_later);
      n_checks++;
      if (bus4.busy !== 1'b0) $display("FAIL %s end busy got %b want 0", name, bus4.busy);
      else n_pass++;
      n_checks++;
      if (bus4.out_valid !== 1'b0) $display("FAIL %s end out_valid got %b want 0", name, bus4.out_valid);
      else n_pass++;
      n_checks++;
      if (bus4.out_diff !== exp[8]) $display("FAIL %s end out_diff hold got %0d want %0d", name, bus4.out_diff, exp[8]);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_image = '0; bus4.mode = 2'd0;
    bus8.in_valid = 1'b0; bus8.in_image = '0; bus8.mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", bus4.out_valid);
    else n_pass++;
    n_checks++;
    if (bus4.out_diff !== 4'd0) $display("FAIL reset out_diff got %0d want 0", bus4.out_diff);
    else n_pass++;
    n_checks++;
    if (bus4.busy !== 1'b0) $display("FAIL reset busy got %b want 0", bus4.busy);
    else n_pass++;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL reset8 valid/busy got %b/%b want 0/0", bus8.out_valid, bus8.busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap;
    run_frame4("wrap", A_INC, B_3, 2'd0, 2'd0, 9'd0, 9'd0, E_WRAP, 1'b1);
  endtask

  task automatic test_modes;
    run_frame4("sat",   A_INC, B_3, 2'd1, 2'd1, 9'd0, 9'd0, E_SAT,   1'b1);
    run_frame4("abs",   A_INC, B_3, 2'd2, 2'd2, 9'd0, 9'd0, E_ABS,   1'b1);
    run_frame4("rwrap", A_INC, B_3, 2'd3, 2'd3, 9'd0, 9'd0, E_RWRAP, 1'b1);
  endtask

  task automatic test_gaps;
    run_frame4("gap_wrap", A_INC, B_3, 2'd0, 2'd1, 9'b010010010, 9'b100100101, E_WRAP, 1'b1);
    run_frame4("gap_rwrap", A_INC, B_3, 2'd3, 2'd2, 9'b001100110, 9'b011001010, E_RWRAP, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_frame4("b2b_f1", A_INC, B_3, 2'd3, 2'd3, 9'd0, 9'd0, E_RWRAP, 1'b0);
    run_frame4("b2b_f2", A_15, B_INC0, 2'd2, 2'd2, 9'd0, 9'd0, E_F2ABS, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 9; k++) beat4(1'b1, A_INC[k], 2'd0);
    for (int k = 0; k < 5; k++) begin
      beat4(1'b1, B_3[k], 2'd0);
      n_checks++;
      if (bus4.out_diff !== E_WRAP[k]) $display("FAIL rstmid pre B%0d out_diff got %0d want %0d", k, bus4.out_diff, E_WRAP[k]);
      else n_pass++;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus4.out_valid !== 1'b0) $display("FAIL rstmid in-reset%0d out_valid got %b want 0", c, bus4.out_valid);
      else n_pass++;
      n_checks++;
      if (bus4.out_diff !== 4'd0) $display("FAIL rstmid in-reset%0d out_diff got %0d want 0", c, bus4.out_diff);
      else n_pass++;
      n_checks++;
      if (bus4.busy !== 1'b0) $display("FAIL rstmid in-reset%0d busy got %b want 0", c, bus4.busy);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      beat4(1'b0, 4'd0, 2'd0);
      n_checks++;
      if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) $display("FAIL rstmid post%0d valid/busy got %b/%b want 0/0", c, bus4.out_valid, bus4.busy);
      else n_pass++;
    end
    run_frame4("rstmid_new", A_INC, B_3, 2'd2, 2'd2, 9'd0, 9'd0, E_ABS, 1'b1);
  endtask

  task automatic test_sweep;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) begin
        beat8(1'b1, 8'(k * 10), (f == 0) ? 2'd1 : 2'd0);
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b1) $display("FAIL sweep f%0d A%0d valid/busy got %b/%b want 0/1", f, k, bus8.out_valid, bus8.busy);
        else n_pass++;
      end
      for (int k = 0; k < 16; k++) begin
        beat8(1'b1, 8'd100, 2'd3);
        n_checks++;
        if (bus8.out_valid !== 1'b1) $display("FAIL sweep f%0d B%0d out_valid got %b want 1", f, k, bus8.out_valid);
        else n_pass++;
        n_checks++;
        if (bus8.out_diff !== ((f == 0) ? E8_SAT[k] : E8_WRAP[k]))
          $display("FAIL sweep f%0d B%0d out_diff got %0d want %0d", f, k, bus8.out_diff, (f == 0) ? E8_SAT[k] : E8_WRAP[k]);
        else n_pass++;
      end
      beat8(1'b0, 8'd0, 2'd0);
      n_checks++;
      if (bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0) $display("FAIL sweep f%0d end busy/valid got %b/%b want 0/0", f, bus8.busy, bus8.out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_modes;
    test_gaps;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
